// File: rtl/alkqsh_if.sv
// Q-register / step-counter bus for the ALK mul/div datapath slice.
// Master drives the datapath controls, slave is the alkqsh block.
interface alkqsh_if #(
  parameter int WIDTH = 32
);

  logic             stall_h;
  logic [1:0]       dq_op_h;
  logic [WIDTH-1:0] wbus_h;
  logic             shr_in_h;
  logic             shl_in_h;
  logic             alpctl_muldiv_h;
  logic             loop_flag_h;

  logic [WIDTH-1:0] q_h;
  logic             q_sout_shr_h;
  logic             q_sout_shl_h;
  logic [5:0]       step_cnt_h;
  logic             last_step_h;
  logic             step_ovf_h;

  modport master (
    output stall_h,
    output dq_op_h,
    output wbus_h,
    output shr_in_h,
    output shl_in_h,
    output alpctl_muldiv_h,
    output loop_flag_h,
    input  q_h,
    input  q_sout_shr_h,
    input  q_sout_shl_h,
    input  step_cnt_h,
    input  last_step_h,
    input  step_ovf_h
  );

  modport slave (
    input  stall_h,
    input  dq_op_h,
    input  wbus_h,
    input  shr_in_h,
    input  shl_in_h,
    input  alpctl_muldiv_h,
    input  loop_flag_h,
    output q_h,
    output q_sout_shr_h,
    output q_sout_shl_h,
    output step_cnt_h,
    output last_step_h,
    output step_ovf_h
  );

endinterface

// File: rtl/alkqsh.sv
// Q-register shifter and multiply/divide step counter for the DPM datapath.
// Q shifts right for multiply, left for divide; the counter times the mul/div loop.
module alkqsh #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input logic   qdclk_l,
  input logic   reset_l,
  alkqsh_if.slave bus
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SQR  = 2'b10;
  localparam logic [1:0] OP_SQL  = 2'b11;

  localparam logic [5:0] STEP_INIT = 6'(STEPS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [5:0]       cnt_q;
  logic [5:0]       cnt_d;
  logic             last_q;
  logic             last_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             setup_cyc;
  logic             loop_cyc;
  logic             last_step;
  logic             advance;

  assign advance   = ~bus.stall_h;
  assign setup_cyc = bus.alpctl_muldiv_h & ~bus.loop_flag_h;
  assign loop_cyc  = bus.alpctl_muldiv_h &  bus.loop_flag_h;
  assign last_step = loop_cyc & (cnt_q == 6'd0);

  // Q path ignores the mul/div qualifier so microcode can shift Q freely.
  always_comb begin
    q_d = q_q;
    if (advance) begin
      case (bus.dq_op_h)
        OP_HOLD: q_d = q_q;
        OP_LOAD: q_d = bus.wbus_h;
        OP_SQR:  q_d = {bus.shr_in_h, q_q[WIDTH-1:1]};
        OP_SQL:  q_d = {q_q[WIDTH-2:0], bus.shl_in_h};
        default: q_d = q_q;
      endcase
    end
  end

  // Counter saturates at zero so an overrun cannot wrap back to 63.
  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      if (setup_cyc) begin
        cnt_d = STEP_INIT;
      end else if (loop_cyc && (cnt_q != 6'd0)) begin
        cnt_d = cnt_q - 6'd1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    ovf_d  = ovf_q;
    if (advance) begin
      last_d = last_step;
      if (setup_cyc) begin
        ovf_d = 1'b0;
      end else if (last_q && last_step) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      q_q    <= '0;
      cnt_q  <= 6'd0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q_h          = q_q;
  assign bus.q_sout_shr_h = q_q[0];
  assign bus.q_sout_shl_h = q_q[WIDTH-1];
  assign bus.step_cnt_h   = cnt_q;
  assign bus.last_step_h  = last_step;
  assign bus.step_ovf_h   = ovf_q;

endmodule

// File: tb/tb_alkqsh.sv
// Scoreboard bench for alkqsh: stimulus queues hand-computed mid-cycle
// expectations, a monitor pops and compares them on the falling clock.
module tb_alkqsh;

  localparam int WIDTH = 32;

  logic qdclk_l = 1'b0;
  logic reset_l = 1'b0;
  bit   sample_req = 1'b0;

  alkqsh_if #(.WIDTH(WIDTH)) bus ();

  alkqsh #(.WIDTH(WIDTH), .STEPS(32)) dut (
    .qdclk_l (qdclk_l),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 qdclk_l = ~qdclk_l;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [5:0]  cnt;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: one expectation per falling edge, plus on-demand mid-cycle samples.
  initial begin
    exp_t e;
    forever begin
      @(negedge qdclk_l or sample_req);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_q"},    bus.q_h,                 e.q);
        checkOutput({e.name, "_cnt"},  32'(bus.step_cnt_h),     32'(e.cnt));
        checkOutput({e.name, "_last"}, 32'(bus.last_step_h),    32'(e.last));
        checkOutput({e.name, "_ovf"},  32'(bus.step_ovf_h),     32'(e.ovf));
        checkOutput({e.name, "_sshr"}, 32'(bus.q_sout_shr_h),   32'(e.q[0]));
        checkOutput({e.name, "_sshl"}, 32'(bus.q_sout_shl_h),   32'(e.q[31]));
      end
    end
  end

  task automatic pushExp(input string name, input logic [31:0] q, input logic [5:0] cnt,
                         input logic last, input logic ovf);
    exp_t e;
    e.name = name;
    e.q    = q;
    e.cnt  = cnt;
    e.last = last;
    e.ovf  = ovf;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic stall, input logic [1:0] op, input logic [31:0] wbus,
                               input logic shr, input logic shl, input logic muldiv,
                               input logic loop, input string name, input logic [31:0] eq,
                               input logic [5:0] ecnt, input logic elast, input logic eovf);
    bus.stall_h         = stall;
    bus.dq_op_h         = op;
    bus.wbus_h          = wbus;
    bus.shr_in_h        = shr;
    bus.shl_in_h        = shl;
    bus.alpctl_muldiv_h = muldiv;
    bus.loop_flag_h     = loop;
    pushExp(name, eq, ecnt, elast, eovf);
    @(posedge qdclk_l);
    #1;
  endtask

  initial begin
    bus.stall_h         = 1'b0;
    bus.dq_op_h         = 2'b00;
    bus.wbus_h          = '0;
    bus.shr_in_h        = 1'b0;
    bus.shl_in_h        = 1'b0;
    bus.alpctl_muldiv_h = 1'b0;
    bus.loop_flag_h     = 1'b0;
    @(posedge qdclk_l);
    #1;
    applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 1, 1, 0, 0, "rst", 32'h0, 6'd0, 0, 0);
    reset_l = 1'b1;

    applyStimulus(0, 2'b01, 32'h8000_0001, 0, 0, 0, 0, "load1", 32'h0, 6'd0, 0, 0);
    applyStimulus(0, 2'b10, 32'h0,         1, 0, 0, 0, "sqr",   32'h8000_0001, 6'd0, 0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 0, 0, "sqr_r", 32'hC000_0000, 6'd0, 0, 0);
    applyStimulus(0, 2'b01, 32'h8000_0001, 0, 0, 0, 0, "load2", 32'hC000_0000, 6'd0, 0, 0);
    applyStimulus(0, 2'b11, 32'h0,         0, 0, 0, 0, "sql",   32'h8000_0001, 6'd0, 0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 0, 0, "sql_r", 32'h0000_0002, 6'd0, 0, 0);

    applyStimulus(0, 2'b00, 32'h0, 0, 0, 1, 0, "setup1", 32'h2, 6'd0, 0, 0);
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(0, 2'b00, 32'h0, 0, 0, 1, 1, $sformatf("loop%0d", k), 32'h2,
                    (k <= 32) ? 6'(32 - k) : 6'd0, (k >= 32), (k == 34));
    end
    applyStimulus(0, 2'b00, 32'h0, 0, 0, 1, 0, "setup2", 32'h2, 6'd0, 0, 1);
    for (int j = 0; j <= 20; j++) begin
      applyStimulus(0, 2'b00, 32'h0, 0, 0, 1, 1, $sformatf("run%0d", j), 32'h2,
                    6'(31 - j), 0, 0);
    end

    for (int s = 0; s < 3; s++) begin
      applyStimulus(1, 2'b10, 32'h0, 1, 0, 1, 1, $sformatf("stall%0d", s), 32'h2, 6'd10, 0, 0);
    end
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 1, 1, "rel1",  32'h2, 6'd10, 0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 1, 1, "rel2",  32'h2, 6'd9,  0, 0);
    applyStimulus(0, 2'b01, 32'h1234_5678, 0, 0, 1, 1, "ldmid", 32'h2, 6'd8,  0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 1, 1, "mid7",  32'h1234_5678, 6'd7, 0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 1, 1, "mid6",  32'h1234_5678, 6'd6, 0, 0);

    bus.stall_h         = 1'b0;
    bus.dq_op_h         = 2'b00;
    bus.alpctl_muldiv_h = 1'b1;
    bus.loop_flag_h     = 1'b1;
    pushExp("mid5", 32'h1234_5678, 6'd5, 0, 0);
    @(negedge qdclk_l);
    #1;
    reset_l             = 1'b0;
    bus.alpctl_muldiv_h = 1'b0;
    bus.loop_flag_h     = 1'b0;
    #1;
    pushExp("arst", 32'h0, 6'd0, 0, 0);
    sample_req = ~sample_req;
    @(posedge qdclk_l);
    #1;
    applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 0, 0, 1, 0, "arst_e1", 32'h0, 6'd0, 0, 0);
    applyStimulus(0, 2'b00, 32'h0,         0, 0, 0, 0, "arst_e2", 32'h0, 6'd0, 0, 0);

    @(negedge qdclk_l);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
